// File: rtl/altmemddr_ex_lfsr_pgc.sv
// Galois LFSR pattern generator with an optional self-seeding, flywheel pattern checker.
// The checker is compiled in only when ALTMEMDDR_EX_LFSR_PGC_CHECKER_EN is defined.
module altmemddr_ex_lfsr_pgc #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(32),
  parameter int unsigned      LOCK_CNT = 4,
  parameter int unsigned      LOSS_CNT = 4,
  parameter int unsigned      ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] data,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             clr_err,
  output logic             chk_locked,
  output logic             chk_err,
  output logic [ERR_W-1:0] err_count
);

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    lfsr_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
  endfunction

  logic [WIDTH-1:0] data_q, data_d;

  // Generator: enable dominates, then load (zero guarded against lock-up), then step unless paused.
  always_comb begin
    data_d = data_q;
    if (!enable)     data_d = SEED;
    else if (load)   data_d = (ldata == '0) ? SEED : ldata;
    else if (!pause) data_d = lfsr_next(data_q);
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= SEED;
    else       data_q <= data_d;
  end

  assign data = data_q;

`ifdef ALTMEMDDR_EX_LFSR_PGC_CHECKER_EN

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d, exp_nxt;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q;
  logic             chk_err_q, chk_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_inc;
  logic             hit;

  assign exp_nxt = lfsr_next(exp_q);
  assign hit     = (chk_data == exp_nxt);

  // Unlocked: reseed from every beat and count consecutive predictions; locked: flywheel on exp.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    chk_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    err_inc   = 1'b0;
    if (!enable) begin
      state_d = ST_UNLOCKED;
      exp_d   = SEED;
      match_d = '0;
      miss_d  = '0;
    end else if (chk_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          exp_d = chk_data;
          if (hit) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == LOCK_N) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          exp_d = exp_nxt;
          if (hit) begin
            miss_d = '0;
          end else begin
            chk_err_d = 1'b1;
            err_inc   = 1'b1;
            miss_d    = miss_q + 4'd1;
            if ((miss_q + 4'd1) == LOSS_N) begin
              state_d = ST_UNLOCKED;
              exp_d   = chk_data;
              match_d = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
    if (clr_err)                         err_cnt_d = '0;
    else if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_UNLOCKED;
      exp_q     <= SEED;
      match_q   <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      chk_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= (state_d == ST_LOCKED);
      chk_err_q <= chk_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign chk_locked = locked_q;
  assign chk_err    = chk_err_q;
  assign err_count  = err_cnt_q;

`else

  // Checker absent: outputs tie off, checker inputs and parameters are deliberately ignored.
  logic unused_chk;
  assign unused_chk = ^{chk_valid, chk_data, clr_err, 4'(LOCK_CNT), 4'(LOSS_CNT)};

  assign chk_locked = 1'b0;
  assign chk_err    = 1'b0;
  assign err_count  = '0;

`endif

endmodule

// File: tb/tb_altmemddr_ex_lfsr_pgc.sv
// Bench for altmemddr_ex_lfsr_pgc: vector table, directed lock/loss/saturation sequences, random run vs model.
// A second instance with a 4-bit error counter receives identical stimulus so saturation is reachable quickly.
module tb_altmemddr_ex_lfsr_pgc;

`ifdef ALTMEMDDR_EX_LFSR_PGC_CHECKER_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int unsigned SEED = 32'h20;
  localparam int unsigned LOCK = 4;
  localparam int unsigned LOSS = 4;

  logic        clk;
  logic        reset, enable, pause, load, chk_valid, clr_err;
  logic [7:0]  ldata, chk_data;
  logic [7:0]  data, data2;
  logic        chk_locked, chk_err, chk_locked2, chk_err2;
  logic [15:0] err_count;
  logic [3:0]  err_count2;

  int tests = 0;
  int fails = 0;

  // Reference state, kept as plain integers.
  int unsigned m_data, m_exp, m_run, m_miss, m_cnt, m_cnt4;
  bit          m_lock, m_err;

  altmemddr_ex_lfsr_pgc dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .load(load), .ldata(ldata),
    .data(data), .chk_valid(chk_valid), .chk_data(chk_data), .clr_err(clr_err),
    .chk_locked(chk_locked), .chk_err(chk_err), .err_count(err_count)
  );

  altmemddr_ex_lfsr_pgc #(.ERR_W(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .load(load), .ldata(ldata),
    .data(data2), .chk_valid(chk_valid), .chk_data(chk_data), .clr_err(clr_err),
    .chk_locked(chk_locked2), .chk_err(chk_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Galois step as polynomial arithmetic: multiply by x, reduce by x^8 + POLY.
  function automatic int unsigned nxt(input int unsigned s);
    int unsigned v;
    v = s * 2;
    if (v > 255) v = (v - 256) ^ 32'h1D;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_update();
    int unsigned e;
    bit inc;
    inc = 1'b0;
    if (reset) begin
      m_data = SEED; m_exp = SEED; m_lock = 1'b0; m_run = 0; m_miss = 0;
      m_err = 1'b0; m_cnt = 0; m_cnt4 = 0;
      return;
    end
    if (!enable)     m_data = SEED;
    else if (load)   m_data = (ldata == 8'h00) ? SEED : 32'(ldata);
    else if (!pause) m_data = nxt(m_data);
    m_err = 1'b0;
    if (CHK_EN) begin
      if (!enable) begin
        m_lock = 1'b0; m_exp = SEED; m_run = 0; m_miss = 0;
      end else if (chk_valid) begin
        e = nxt(m_exp);
        if (!m_lock) begin
          m_exp = 32'(chk_data);
          if (32'(chk_data) == e) begin
            m_run++;
            if (m_run == LOCK) begin m_lock = 1'b1; m_miss = 0; end
          end else begin
            m_run = 0;
          end
        end else begin
          m_exp = e;
          if (32'(chk_data) == e) m_miss = 0;
          else begin
            m_err = 1'b1; inc = 1'b1; m_miss++;
            if (m_miss == LOSS) begin
              m_lock = 1'b0; m_exp = 32'(chk_data); m_run = 0; m_miss = 0;
            end
          end
        end
      end
    end
    if (clr_err) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (inc) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  // One clock: predict, clock, then sample away from the edge and compare everything.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("data",       64'(data),       64'(m_data));
    check("chk_locked", 64'(chk_locked), 64'(m_lock));
    check("chk_err",    64'(chk_err),    64'(m_err));
    check("err_count",  64'(err_count),  64'(m_cnt));
    check("err_cnt4",   64'(err_count2), 64'(m_cnt4));
  endtask

  typedef struct {
    logic       rst, en, ps, ld;
    logic [7:0] ldat;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h1D};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3A};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h74};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE8};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hCD};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA5};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA5};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA5};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h20};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hB4};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h75};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h20};

    reset = 1'b1; enable = 1'b0; pause = 1'b0; load = 1'b0; ldata = 8'h00;
    chk_valid = 1'b0; chk_data = 8'h00; clr_err = 1'b0;

    // Generator vector table, checker idle.
    for (int i = 0; i < 19; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; pause = vecs[i].ps;
      load = vecs[i].ld; ldata = vecs[i].ldat;
      step();
      check("vec_data", 64'(data), 64'(vecs[i].exp_data));
    end
    check("rst_locked", 64'(chk_locked), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);

    // Loopback right after reset: lock exactly five cycles after the first beat.
    reset = 1'b0; enable = 1'b1; pause = 1'b0; load = 1'b0; chk_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      chk_data = data;
      step();
      check("lock_rise", 64'(chk_locked), 64'(CHK_EN && i >= 5));
      check("lock_noerr", 64'(chk_err), 64'd0);
    end

    // Single corrupted beat while locked.
    chk_data = data ^ 8'h01;
    step();
    check("single_err", 64'(chk_err), 64'(CHK_EN));
    check("single_cnt", 64'(err_count), CHK_EN ? 64'd1 : 64'd0);
    check("single_lock", 64'(chk_locked), 64'(CHK_EN));
    chk_data = data;
    step();
    check("single_clear", 64'(chk_err), 64'd0);

    // Four corrupted beats in a row lose lock; clean beats reseed then relock.
    for (int k = 0; k < 4; k++) begin
      chk_data = data ^ 8'h01;
      step();
    end
    check("loss_cnt", 64'(err_count), CHK_EN ? 64'd5 : 64'd0);
    check("loss_lock", 64'(chk_locked), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      chk_data = data;
      step();
      check("relock", 64'(chk_locked), 64'(CHK_EN && i >= 5));
    end

    // Three bad / one good keeps lock while piling up errors past the 4-bit ceiling.
    for (int n = 0; n < 28; n++) begin
      chk_data = (n % 4 == 3) ? data : (data ^ 8'h01);
      step();
    end
    check("sat_cnt16", 64'(err_count), CHK_EN ? 64'd26 : 64'd0);
    check("sat_cnt4", 64'(err_count2), CHK_EN ? 64'hF : 64'd0);
    check("sat_lock", 64'(chk_locked), 64'(CHK_EN));

    // Clear wins over a simultaneous error, pulse still fires.
    chk_data = data ^ 8'h01; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_cnt", 64'(err_count), 64'd0);
    check("clr_cnt4", 64'(err_count2), 64'd0);
    check("clr_err_pulse", 64'(chk_err), 64'(CHK_EN));

    // Reset while locked with three errors logged, mid-load and with a bad beat present.
    chk_data = data;
    step();
    for (int k = 0; k < 3; k++) begin
      chk_data = data ^ 8'h01;
      step();
    end
    check("pre_rst_cnt", 64'(err_count), CHK_EN ? 64'd3 : 64'd0);
    check("pre_rst_lock", 64'(chk_locked), 64'(CHK_EN));
    reset = 1'b1; load = 1'b1; ldata = 8'h77; chk_data = data ^ 8'h01;
    step();
    check("rst_lock", 64'(chk_locked), 64'd0);
    check("rst_cnt", 64'(err_count), 64'd0);
    check("rst_data", 64'(data), 64'h20);
    reset = 1'b0; load = 1'b0;

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      enable    = ($urandom_range(0, 63) != 0);
      pause     = ($urandom_range(0, 7) == 0);
      load      = ($urandom_range(0, 47) == 0);
      ldata     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      chk_valid = ($urandom_range(0, 7) != 0);
      chk_data  = ($urandom_range(0, 11) == 0) ? (data ^ 8'(1 << $urandom_range(0, 7))) : data;
      clr_err   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
